// File: rtl/fp16_pkg.sv
// Shared half-precision constants and encodings.
// The multiplier and the adder use the same definitions.
package fp16_pkg;
  localparam int EXP_W    = 5;
  localparam int FRAC_W   = 10;
  localparam int EXP_BIAS = 15;

  localparam logic [15:0] FP16_POS_INF = 16'h7C00;
  localparam logic [15:0] FP16_ZERO    = 16'h0000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    NORM   = 2'd2
  } state_t;

  // Operand class captured at the accepting edge
  typedef enum logic [1:0] {
    K_NORMAL  = 2'd0,
    K_DIVZERO = 2'd1,
    K_ZERO    = 2'd2
  } kind_t;
endpackage

// File: rtl/fp16_divide_if.sv
// Operand/result bundle of the fp16 divider with its start/ready handshake.
interface fp16_divide_if;
  logic [15:0] in_A;
  logic [15:0] in_B;
  logic        in_En;
  logic [15:0] out_Out;
  logic        out_Ready;
  logic        out_Busy;
  logic        out_DivZero;

  modport master (
    output in_A, in_B, in_En,
    input  out_Out, out_Ready, out_Busy, out_DivZero
  );

  modport slave (
    input  in_A, in_B, in_En,
    output out_Out, out_Ready, out_Busy, out_DivZero
  );
endinterface

// File: rtl/fp16_div_mantissa.sv
// Restoring mantissa divider: one quotient bit per clock, 12 bits in 12 clocks.
// o_done is high during the cycle whose closing edge produces q[0].
module fp16_div_mantissa
  import fp16_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                i_start,
  input  logic [FRAC_W-1:0]   i_a_frac,
  input  logic [FRAC_W-1:0]   i_b_frac,
  output logic                o_done,
  output logic [FRAC_W+1:0]   o_q
);
  localparam int MW = FRAC_W + 2;

  logic [MW-1:0]     r_rem;
  logic [FRAC_W:0]   r_div;
  logic [MW-1:0]     r_q;
  logic [3:0]        r_cnt;
  logic              r_run;

  logic              w_ge;
  logic [MW-1:0]     w_diff;
  logic [MW-1:0]     w_keep;

  assign w_ge   = (r_rem >= {1'b0, r_div});
  assign w_diff = r_rem - {1'b0, r_div};
  // The remainder stays below 2*D, so the shift never drops a set bit
  assign w_keep = w_ge ? w_diff : r_rem;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rem <= '0;
      r_div <= '0;
      r_q   <= '0;
      r_cnt <= '0;
      r_run <= 1'b0;
    end else if (i_start) begin
      r_rem <= {1'b0, 1'b1, i_a_frac};
      r_div <= {1'b1, i_b_frac};
      r_q   <= '0;
      r_cnt <= 4'(MW - 1);
      r_run <= 1'b1;
    end else if (r_run) begin
      r_q[r_cnt] <= w_ge;
      r_rem      <= w_keep << 1;
      if (r_cnt == 4'd0) begin
        r_run <= 1'b0;
      end else begin
        r_cnt <= r_cnt - 4'd1;
      end
    end
  end

  assign o_done = r_run && (r_cnt == 4'd0);
  assign o_q    = r_q;
endmodule

// File: rtl/fp16_divide.sv
// Half-precision divider top: sign/exponent path, special-operand decode,
// normalisation of the mantissa quotient and the En/Ready handshake.
module fp16_divide
  import fp16_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  fp16_divide_if.slave  bus
);
  state_t             r_state, w_state_nxt;
  kind_t              r_kind, w_kind;
  logic               r_sign;
  logic [EXP_W-1:0]   r_exp;
  logic [15:0]        r_out;
  logic               r_ready;
  logic               r_dz;

  logic [EXP_W-1:0]   w_a_exp, w_b_exp;
  logic               w_accept, w_start, w_done, w_complete;
  logic [FRAC_W+1:0]  w_q;
  logic [FRAC_W-1:0]  w_frac;
  logic [EXP_W-1:0]   w_exp_n;
  logic [15:0]        w_result;

  assign w_a_exp  = bus.in_A[14:10];
  assign w_b_exp  = bus.in_B[14:10];
  assign w_accept = (r_state == IDLE) && bus.in_En;
  // A zero divisor wins over a zero dividend
  assign w_kind   = (w_b_exp == '0) ? K_DIVZERO :
                    (w_a_exp == '0) ? K_ZERO : K_NORMAL;
  assign w_start  = w_accept && (w_kind == K_NORMAL);

  fp16_div_mantissa u_mant (
    .clk      (clk),
    .rst      (rst),
    .i_start  (w_start),
    .i_a_frac (bus.in_A[FRAC_W-1:0]),
    .i_b_frac (bus.in_B[FRAC_W-1:0]),
    .o_done   (w_done),
    .o_q      (w_q)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_complete  = 1'b0;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = (w_kind == K_NORMAL) ? DIVIDE : NORM;
      DIVIDE:  if (w_done) w_state_nxt = NORM;
      NORM: begin
        w_state_nxt = IDLE;
        w_complete  = 1'b1;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Quotient lies in (0.5, 2): shift left once when the integer bit is clear
  assign w_frac  = w_q[FRAC_W+1] ? w_q[FRAC_W:1] : w_q[FRAC_W-1:0];
  assign w_exp_n = w_q[FRAC_W+1] ? r_exp : r_exp - 5'd1;

  always_comb begin
    w_result = {r_sign, w_exp_n, w_frac};
    case (r_kind)
      K_DIVZERO: w_result = {r_sign, FP16_POS_INF[14:0]};
      K_ZERO:    w_result = {r_sign, FP16_ZERO[14:0]};
      default:   w_result = {r_sign, w_exp_n, w_frac};
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_kind  <= K_NORMAL;
      r_sign  <= 1'b0;
      r_exp   <= '0;
      r_out   <= FP16_ZERO;
      r_ready <= 1'b0;
      r_dz    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ready <= w_complete;
      if (w_accept) begin
        r_kind <= w_kind;
        r_sign <= bus.in_A[15] ^ bus.in_B[15];
        r_exp  <= w_a_exp - w_b_exp + 5'(EXP_BIAS);
      end
      if (w_complete) begin
        r_out <= w_result;
        r_dz  <= (r_kind == K_DIVZERO);
      end
    end
  end

  assign bus.out_Out     = r_out;
  assign bus.out_Ready   = r_ready;
  assign bus.out_Busy    = (r_state != IDLE);
  assign bus.out_DivZero = r_dz;
endmodule

// File: tb/tb_fp16_divide.sv
// Bench for fp16_divide: vector table plus hand sequences, results checked
// through an expected-result queue popped on every out_Ready pulse.
module tb_fp16_divide;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fp16_divide_if bus ();

  fp16_divide dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] out;
    logic        dz;
  } vec_t;

  typedef struct {
    logic [15:0] out;
    logic        dz;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at cycle %0d", name, act, req, cyc);
    end
  endtask

  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b);
    exp_t        e;
    logic        s;
    logic [4:0]  ex;
    int          qi;
    logic [11:0] q;
    s  = a[15] ^ b[15];
    ex = a[14:10] - b[14:10] + 5'd15;
    qi = (int'({1'b1, a[9:0]}) * 2048) / int'({1'b1, b[9:0]});
    q  = qi[11:0];
    e.acc = 0;
    if (b[14:10] == 5'd0) begin
      e.out = {s, 5'h1F, 10'h000}; e.dz = 1'b1; e.lat = 1;
    end else if (a[14:10] == 5'd0) begin
      e.out = {s, 15'h0000}; e.dz = 1'b0; e.lat = 1;
    end else begin
      e.dz = 1'b0; e.lat = 13;
      if (q[11]) e.out = {s, ex, q[10:1]};
      else       e.out = {s, ex - 5'd1, q[9:0]};
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst === 1'b1 && bus.out_Ready === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ready out=%h at cycle %0d", bus.out_Out, cyc);
      end else begin
        mon_e = sb.pop_front();
        check("out_Out", 32'(bus.out_Out), 32'(mon_e.out));
        check("out_DivZero", 32'(bus.out_DivZero), 32'(mon_e.dz));
        check("latency", 32'(cyc - mon_e.acc), 32'(mon_e.lat));
      end
    end
  end

  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input exp_t e);
    int n = 0;
    while (bus.out_Busy === 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("busy_timeout", 32'(bus.out_Busy), 32'd0);
    bus.in_A  = a;
    bus.in_B  = b;
    bus.in_En = 1'b1;
    @(posedge clk);
    #1;
    e.acc = cyc;
    sb.push_back(e);
    bus.in_En = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() > 0 && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (sb.size() > 0) begin
      check("drain_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  vec_t vecs[10];
  exp_t e;

  initial begin
    vecs[0] = '{16'h4600, 16'h4000, 16'h4200, 1'b0};  // 6.0 / 2.0
    vecs[1] = '{16'h3C00, 16'h4200, 16'h3555, 1'b0};  // 1.0 / 3.0
    vecs[2] = '{16'hC780, 16'h4100, 16'hC200, 1'b0};  // -7.5 / 2.5
    vecs[3] = '{16'h5640, 16'hC900, 16'hC900, 1'b0};  // 100 / -10
    vecs[4] = '{16'h3C00, 16'h3E00, 16'h3955, 1'b0};  // 1.0 / 1.5
    vecs[5] = '{16'h7800, 16'h0400, 16'h3000, 1'b0};  // exponent wraps
    vecs[6] = '{16'h3C00, 16'h0000, 16'h7C00, 1'b1};  // divide by zero
    vecs[7] = '{16'h0000, 16'h4500, 16'h0000, 1'b0};  // zero dividend
    vecs[8] = '{16'h0000, 16'h0000, 16'h7C00, 1'b1};  // 0/0: div-zero wins
    vecs[9] = '{16'hBC00, 16'h0000, 16'hFC00, 1'b1};  // signed div by zero

    bus.in_A  = 16'h0000;
    bus.in_B  = 16'h0000;
    bus.in_En = 1'b0;
    rst       = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_out", 32'(bus.out_Out), 32'h0);
    check("rst_ready", 32'(bus.out_Ready), 32'h0);
    check("rst_busy", 32'(bus.out_Busy), 32'h0);
    check("rst_dz", 32'(bus.out_DivZero), 32'h0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      e.out = vecs[i].out;
      e.dz  = vecs[i].dz;
      e.lat = (vecs[i].a[14:10] == 5'd0 || vecs[i].b[14:10] == 5'd0) ? 1 : 13;
      e.acc = 0;
      do_op(vecs[i].a, vecs[i].b, e);
    end
    drain();

    // Back-to-back: new request in the out_Ready cycle
    do_op(16'hC780, 16'h4100, model(16'hC780, 16'h4100));
    begin
      int n = 0;
      @(negedge clk);
      while (bus.out_Ready !== 1'b1 && n < 50) begin
        @(negedge clk);
        n++;
      end
      check("b2b_ready_seen", 32'(bus.out_Ready), 32'd1);
      check("b2b_busy_low", 32'(bus.out_Busy), 32'd0);
      bus.in_A  = 16'h4000;
      bus.in_B  = 16'h3C00;
      bus.in_En = 1'b1;
      @(posedge clk);
      #1;
      e = '{16'h4000, 1'b0, 13, cyc};
      sb.push_back(e);
      bus.in_En = 1'b0;
    end
    drain();

    // Held in_En while busy must not start extra operations
    @(negedge clk);
    bus.in_A  = 16'h4600;
    bus.in_B  = 16'h4000;
    bus.in_En = 1'b1;
    @(posedge clk);
    #1;
    e = '{16'h4200, 1'b0, 13, cyc};
    sb.push_back(e);
    repeat (5) begin
      @(negedge clk);
      bus.in_A = 16'(32'h3800 + $urandom_range(0, 16'h0FFF));
      bus.in_B = 16'(32'h4400 + $urandom_range(0, 16'h0FFF));
      check("hold_busy", 32'(bus.out_Busy), 32'd1);
    end
    bus.in_En = 1'b0;
    drain();

    // Asynchronous reset in the middle of DIVIDE
    do_op(16'h4600, 16'h4000, model(16'h4600, 16'h4000));
    repeat (6) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_out", 32'(bus.out_Out), 32'h0);
    check("mid_rst_ready", 32'(bus.out_Ready), 32'h0);
    check("mid_rst_busy", 32'(bus.out_Busy), 32'h0);
    check("mid_rst_dz", 32'(bus.out_DivZero), 32'h0);
    sb.delete();
    @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    check("post_rst_idle", 32'(bus.out_Busy), 32'h0);
    do_op(16'h3C00, 16'h4200, model(16'h3C00, 16'h4200));
    drain();

    // Random operands against the arithmetic model
    for (int i = 0; i < 24; i++) begin
      logic [15:0] ra, rb;
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (i % 8 == 3) rb[14:10] = 5'd0;
      if (i % 8 == 5) ra[14:10] = 5'd0;
      do_op(ra, rb, model(ra, rb));
    end
    drain();

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fp16_divide.md
Name: fp16_divide

Overview:
- Half-precision (1/5/10) floating-point divider, out_Out = in_A / in_B.
- Inverse operation to the team's fp16 multiplier, used by the neuron datapath for normalisation and weight scaling.
- Same in_En/out_Ready handshake style as the multiplier.
- Iterative restoring mantissa division, one quotient bit per clock. Arithmetic conventions match the multiplier: no subnormals, no NaN handling, truncation (no rounding), 5-bit exponent wraps modulo 32.

Parameters:
- EXP_W, 5, exponent field width.
- FRAC_W, 10, stored fraction width. The hidden bit is implicit.
- EXP_BIAS, 15, exponent bias.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset. Asserting it (0) immediately forces reset state.
- in_A  in  16  dividend.
- in_B  in  16  divisor.
- in_En  in  1  start request. Sampled on rising clk only in IDLE.
- out_Out  out  16  quotient. Held until the next completion.
- out_Ready  out  1  one-cycle pulse: out_Out is newly valid.
- out_Busy  out  1  high while an operation is in flight; in_En is ignored while high.
- out_DivZero  out  1  sticky per result. High with out_Ready when in_B is zero; otherwise cleared at the next completion.

Behaviour:
- Reset (rst=0, async):
  - out_Out=16'h0000, out_Ready=0, out_Busy=0, out_DivZero=0.
  - state=IDLE, iteration counter=0, working registers cleared.
  - Reset mid-operation abandons the operation; no out_Ready is produced.
- States: IDLE, DIVIDE, NORM.
- IDLE, in_En=1 at edge E0, normal operands:
  - Capture sign = A[15]^B[15].
  - Capture exp = A.e - B.e + EXP_BIAS, computed 5-bit modulo 32.
  - Remainder R(12b) = {0,1,A.f}; divisor D = {1,B.f}; cnt = 11.
  - out_Busy=1; go to DIVIDE.
- DIVIDE, each edge:
  - If R>=D: q[cnt]=1 and R=(R-D)<<1. Else q[cnt]=0 and R=R<<1.
  - cnt decrements. Leave for NORM after the edge computing q[0]; DIVIDE lasts 12 edges (E1..E12).
- NORM, edge E13:
  - If q[11]=1: fraction = q[10:1], exponent = exp.
  - Else: fraction = q[9:0], exponent = exp-1 (5-bit wrap).
  - out_Out = {sign, exponent, fraction}; out_Ready=1; out_DivZero=0; out_Busy=0; go to IDLE.
  - Latency: 13 clocks from accepting edge to out_Ready high.
- Special cases, resolved at E0+1 without entering DIVIDE:
  - B.e==0 (divisor zero): out_Out = {sign,5'h1F,10'h0}, out_DivZero=1, out_Ready=1. This case wins when A is also zero.
  - A.e==0, B nonzero: out_Out = {sign,15'h0}, out_DivZero=0, out_Ready=1.
  - out_Busy is high for that single cycle.
- out_Ready:
  - High for exactly one cycle after the completing edge, low otherwise.
  - in_En=1 in the cycle out_Ready is high (state already IDLE) is accepted: back-to-back operation is supported.
- Operands are captured at E0; in_A/in_B may change afterwards without effect.
- Exponent overflow and underflow wrap silently, as in the multiplier. No saturation.

Decomposition:
- Shared package fp16_pkg holds:
  - EXP_W, FRAC_W, EXP_BIAS.
  - FP16_POS_INF=16'h7C00 and FP16_ZERO=16'h0000.
  - The state encoding (IDLE=2'd0, DIVIDE=2'd1, NORM=2'd2).
  - The same constants are reused by the multiplier and any adder.
- One sub-module is natural: fp16_div_mantissa.
  - Contains the 12-cycle restoring-division core: R/D/q/cnt registers, start/done handshake.
  - The top holds sign, exponent, special-case decode and normalisation.

Test Plan:
- Reset, then 0x4600 / 0x4000 (6.0/2.0) -> out_Ready 13 clocks after the accepting edge, out_Out=0x4200, out_DivZero=0.
- 0x3C00 / 0x4200 (1.0/3.0) -> out_Out=0x3555 (q[11]=0 normalisation path, truncated), exponent field 13.
- 0xC780 / 0x4100 (-7.5/2.5) -> 0xC200. Immediately issue 0x4000/0x3C00 with in_En in the out_Ready cycle -> second result 0x4000 exactly 13 clocks later.
- 0x3C00 / 0x0000 -> one cycle later out_Out=0x7C00, out_DivZero=1, out_Ready pulse. Then 0x0000/0x4500 -> out_Out=0x0000, out_DivZero=0.
- Start 0x4600/0x4000, hold in_En=1 with different operands for 5 cycles -> single result 0x4200, extra requests ignored, out_Busy high throughout.
- Start an operation, drive rst=0 at cycle 6 mid-DIVIDE -> all outputs 0 immediately. After release, no out_Ready until a new in_En; a new operation completes correctly.
